// File: rtl/k_means_pkg.sv
// Shared constants, FSM state type and packing helpers for the k-means new-centroid stage.
// Optional NEW_MEANS_ROUND_EN widens the divide by one bit for round-half-up averages.
package k_means_pkg;

  localparam int unsigned CENT_NUM     = 8;
  localparam int unsigned COORD_NUM    = 7;
  localparam int unsigned CORD_W       = 13;
  localparam int unsigned ACCUM_CORD_W = 22;
  localparam int unsigned CNT_W        = 10;
  localparam int unsigned CENT_IDX_W   = 3;
  localparam int unsigned DATA_W       = COORD_NUM * CORD_W;
  localparam int unsigned ACCUM_W      = COORD_NUM * ACCUM_CORD_W;

`ifdef NEW_MEANS_ROUND_EN
  localparam int unsigned DIV_W = ACCUM_CORD_W + 1;
`else
  localparam int unsigned DIV_W = ACCUM_CORD_W;
`endif
  localparam int unsigned ITER_W = $clog2(DIV_W);

  localparam logic [CORD_W-1:0] CORD_MAX = '1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_DIVIDE,
    ST_WRITE,
    ST_DONE
  } new_means_state_t;

  // Coordinate k of a packed accumulator word.
  function automatic logic [ACCUM_CORD_W-1:0] accum_coord(input logic [ACCUM_W-1:0] a,
                                                          input int unsigned k);
    return a[k*ACCUM_CORD_W +: ACCUM_CORD_W];
  endfunction

  // Clamp a quotient into the coordinate range.
  function automatic logic [CORD_W-1:0] sat_coord(input logic [DIV_W-1:0] q);
    if (q > DIV_W'(CORD_MAX)) return CORD_MAX;
    return q[CORD_W-1:0];
  endfunction

endpackage

// File: rtl/serial_divider.sv
// Unsigned restoring divider: one quotient bit per step, dividend consumed MSB-first.
module serial_divider #(
  parameter int unsigned DVD_W = 22,
  parameter int unsigned DVS_W = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             step,
  input  logic [DVD_W-1:0] dividend,
  input  logic [DVS_W-1:0] divisor,
  output logic [DVD_W-1:0] quotient
);

  logic [DVD_W-1:0] dvd_q;
  logic [DVS_W-1:0] dvs_q;
  logic [DVS_W-1:0] rem_q;
  logic [DVS_W:0]   rem_shift_c;

  // Remainder stays below the divisor, so one extra bit holds the shifted value.
  assign rem_shift_c = {rem_q, dvd_q[DVD_W-1]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dvd_q    <= '0;
      dvs_q    <= '0;
      rem_q    <= '0;
      quotient <= '0;
    end else if (load) begin
      dvd_q    <= dividend;
      dvs_q    <= divisor;
      rem_q    <= '0;
      quotient <= '0;
    end else if (step) begin
      dvd_q <= dvd_q << 1;
      if (rem_shift_c >= {1'b0, dvs_q}) begin
        rem_q    <= DVS_W'(rem_shift_c - {1'b0, dvs_q});
        quotient <= {quotient[DVD_W-2:0], 1'b1};
      end else begin
        rem_q    <= DVS_W'(rem_shift_c);
        quotient <= {quotient[DVD_W-2:0], 1'b0};
      end
    end
  end

endmodule

// File: rtl/new_means_calc.sv
// New-centroid calculator: divides each cluster's accumulators by its count and emits centroids serially.
// Define NEW_MEANS_ROUND_EN for round-half-up instead of truncation.
module new_means_calc
  import k_means_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [ACCUM_W-1:0]    accum_1,
  input  logic [ACCUM_W-1:0]    accum_2,
  input  logic [ACCUM_W-1:0]    accum_3,
  input  logic [ACCUM_W-1:0]    accum_4,
  input  logic [ACCUM_W-1:0]    accum_5,
  input  logic [ACCUM_W-1:0]    accum_6,
  input  logic [ACCUM_W-1:0]    accum_7,
  input  logic [ACCUM_W-1:0]    accum_8,
  input  logic [CNT_W-1:0]      cnt_1,
  input  logic [CNT_W-1:0]      cnt_2,
  input  logic [CNT_W-1:0]      cnt_3,
  input  logic [CNT_W-1:0]      cnt_4,
  input  logic [CNT_W-1:0]      cnt_5,
  input  logic [CNT_W-1:0]      cnt_6,
  input  logic [CNT_W-1:0]      cnt_7,
  input  logic [CNT_W-1:0]      cnt_8,
  input  logic [DATA_W-1:0]     old_centroid,
  output logic [DATA_W-1:0]     new_centroid,
  output logic [CENT_IDX_W-1:0] cent_cnt,
  output logic                  new_centroid_valid,
  output logic                  empty_cluster,
  output logic                  busy,
  output logic                  done
);

  new_means_state_t      state;
  logic [CENT_IDX_W-1:0] idx;
  logic [ITER_W-1:0]     iter;
  logic                  empty_q;

  logic [ACCUM_W-1:0]    cur_accum_c;
  logic [CNT_W-1:0]      cur_cnt_c;
  logic                  load_c;
  logic                  step_c;
  logic [DIV_W-1:0]      dividend_c [COORD_NUM];
  logic [DIV_W-1:0]      quot       [COORD_NUM];
  logic [DATA_W-1:0]     sat_c;

  // Select the accumulator/count pair of the centroid being worked on.
  always_comb begin
    cur_accum_c = '0;
    cur_cnt_c   = '0;
    case (idx)
      3'd0: begin cur_accum_c = accum_1; cur_cnt_c = cnt_1; end
      3'd1: begin cur_accum_c = accum_2; cur_cnt_c = cnt_2; end
      3'd2: begin cur_accum_c = accum_3; cur_cnt_c = cnt_3; end
      3'd3: begin cur_accum_c = accum_4; cur_cnt_c = cnt_4; end
      3'd4: begin cur_accum_c = accum_5; cur_cnt_c = cnt_5; end
      3'd5: begin cur_accum_c = accum_6; cur_cnt_c = cnt_6; end
      3'd6: begin cur_accum_c = accum_7; cur_cnt_c = cnt_7; end
      3'd7: begin cur_accum_c = accum_8; cur_cnt_c = cnt_8; end
      default: ;
    endcase
  end

  assign load_c = (state == ST_LOAD);
  assign step_c = (state == ST_DIVIDE);

  for (genvar k = 0; k < COORD_NUM; k++) begin : g_div
`ifdef NEW_MEANS_ROUND_EN
    // Adding half the count before truncating gives round-half-up.
    assign dividend_c[k] = DIV_W'(accum_coord(cur_accum_c, k)) + DIV_W'(cur_cnt_c >> 1);
`else
    assign dividend_c[k] = accum_coord(cur_accum_c, k);
`endif

    serial_divider #(
      .DVD_W (DIV_W),
      .DVS_W (CNT_W)
    ) u_div (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (load_c),
      .step     (step_c),
      .dividend (dividend_c[k]),
      .divisor  (cur_cnt_c),
      .quotient (quot[k])
    );
  end

  always_comb begin
    sat_c = '0;
    for (int unsigned k = 0; k < COORD_NUM; k++) begin
      sat_c[k*CORD_W +: CORD_W] = sat_coord(quot[k]);
    end
  end

  // Controller with registered outputs; cent_cnt follows idx from LOAD so it labels the emitted centroid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state              <= ST_IDLE;
      idx                <= '0;
      iter               <= '0;
      empty_q            <= 1'b0;
      new_centroid       <= '0;
      cent_cnt           <= '0;
      new_centroid_valid <= 1'b0;
      empty_cluster      <= 1'b0;
      busy               <= 1'b0;
      done               <= 1'b0;
    end else begin
      new_centroid_valid <= 1'b0;
      empty_cluster      <= 1'b0;
      done               <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            state    <= ST_LOAD;
            idx      <= '0;
            cent_cnt <= '0;
            busy     <= 1'b1;
          end
        end
        ST_LOAD: begin
          cent_cnt <= idx;
          empty_q  <= (cur_cnt_c == '0);
          iter     <= '0;
          state    <= (cur_cnt_c == '0) ? ST_WRITE : ST_DIVIDE;
        end
        ST_DIVIDE: begin
          iter <= iter + 1'b1;
          if (iter == ITER_W'(DIV_W - 1)) state <= ST_WRITE;
        end
        ST_WRITE: begin
          new_centroid_valid <= 1'b1;
          empty_cluster      <= empty_q;
          new_centroid       <= empty_q ? old_centroid : sat_c;
          if (idx == CENT_IDX_W'(CENT_NUM - 1)) begin
            state <= ST_DONE;
          end else begin
            idx   <= idx + 1'b1;
            state <= ST_LOAD;
          end
        end
        ST_DONE: begin
          done     <= 1'b1;
          busy     <= 1'b0;
          cent_cnt <= '0;
          state    <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
